// File: rtl/uart_pkg.sv
// Shared UART types and helpers for uart_tx and uart_rx.
// Latency: n/a (types, constants and an elaboration-time function only).
// Backpressure: n/a.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_ODD,
    PAR_EVEN
  } parity_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  // Integer cycles per bit; the remainder is dropped, matching the receiver.
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled, pulses bit_end on the terminal count.
// Latency: bit_end is combinational from the count; the count wraps to 0 on the same edge.
// Backpressure: none; clear restarts the bit period from 0 on the next edge.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clock,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic bit_end
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] TERM = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  assign bit_end = enable && (cnt == TERM);

  // Free-running bit timer, restarted on clear and wrapped on the terminal count.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear || bit_end) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one byte per request, start + 8 data (LSB first) + optional parity + 1/2 stop bits.
// Latency: tx falls on the acceptance edge; tx_done pulses one cycle after the last stop bit ends.
// Backpressure: tx_busy high during a frame; tx_send is ignored (not queued) while busy.
module uart_tx
  import uart_pkg::*;
#(
  parameter int      CLK_FREQ     = 100_000_000,
  parameter int      BAUD         = 115_200,
  parameter int      CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD),
  parameter parity_t PARITY       = PAR_NONE,
  parameter int      STOP_BITS    = 1
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_send,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 tx
);

  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_tx: CLKS_PER_BIT must be at least 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end

  localparam logic       PAR_EN    = (PARITY != PAR_NONE);
  localparam logic       PAR_ODD_B = (PARITY == PAR_ODD);
  localparam logic       LAST_STOP = (STOP_BITS == 2);
  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);

  tx_state_t            state, state_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic [2:0]           bit_idx, bit_idx_n;
  logic                 stop_idx, stop_idx_n;
  logic                 par_bit, par_n;
  logic                 tx_n, busy_n, done_n;
  logic                 bit_end, last_stop, accept;

  // The final stop-bit edge doubles as an acceptance edge so that a held
  // request restarts with no idle gap; tx_busy never drops in that case.
  assign last_stop = (state == STOP) && bit_end && (stop_idx == LAST_STOP);
  assign accept    = tx_send && ((state == IDLE) || last_stop);

  uart_baud_cnt #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clock   (clock),
    .rst     (rst),
    .clear   (accept),
    .enable  (state != IDLE),
    .bit_end (bit_end)
  );

  // State, datapath and registered line outputs.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      par_bit  <= 1'b0;
      tx       <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      state    <= state_n;
      shreg    <= shreg_n;
      bit_idx  <= bit_idx_n;
      stop_idx <= stop_idx_n;
      par_bit  <= par_n;
      tx       <= tx_n;
      tx_busy  <= busy_n;
      tx_done  <= done_n;
    end
  end

  // Next-state and next-output logic; tx only moves at bit boundaries or on acceptance.
  always_comb begin
    state_n    = state;
    shreg_n    = shreg;
    bit_idx_n  = bit_idx;
    stop_idx_n = stop_idx;
    par_n      = par_bit;
    tx_n       = tx;
    busy_n     = tx_busy;
    done_n     = 1'b0;

    case (state)
      IDLE: begin
        tx_n = 1'b1;
      end
      START: begin
        if (bit_end) begin
          state_n = DATA;
          tx_n    = shreg[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx == LAST_BIT) begin
            bit_idx_n  = '0;
            stop_idx_n = 1'b0;
            if (PAR_EN) begin
              state_n = uart_pkg::PARITY;
              tx_n    = par_bit;
            end else begin
              state_n = STOP;
              tx_n    = 1'b1;
            end
          end else begin
            bit_idx_n = bit_idx + 3'd1;
            shreg_n   = shreg >> 1;
            tx_n      = shreg[1];
          end
        end
      end
      uart_pkg::PARITY: begin
        if (bit_end) begin
          state_n    = STOP;
          stop_idx_n = 1'b0;
          tx_n       = 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (stop_idx == LAST_STOP) begin
            state_n = IDLE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end else begin
            stop_idx_n = stop_idx + 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
        busy_n  = 1'b0;
      end
    endcase

    if (accept) begin
      state_n   = START;
      shreg_n   = tx_data;
      par_n     = (^tx_data) ^ PAR_ODD_B;
      bit_idx_n = '0;
      tx_n      = 1'b0;
      busy_n    = 1'b1;
    end
  end

endmodule
